// File: rtl/seq_pattern_match_pkg.sv
// Shared types and elaboration helpers for the sequence pattern matcher.
// Holds the FSM state encoding and a ceiling-log2 used to size index and fill counters.
package spm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ARMED
    } state_t;

    // Never returns less than 1, so counters for DEPTH=1 still get a real bit.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = 1;
        while (x < v) begin
            x = x * 2;
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seq_pattern_match_if.sv
// Pattern-load, stream and status signals of the sequence pattern matcher.
// master = data source / monitor side, slave = the matcher.
interface seq_pattern_match_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             load_start;
    logic             pat_valid;
    logic [WIDTH-1:0] pat_data;
    logic [WIDTH-1:0] pat_mask;
    logic             pat_ready;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             cnt_clr;
    logic             armed;
    logic             hit;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output load_start, pat_valid, pat_data, pat_mask, in_valid, in_data, cnt_clr,
        input  pat_ready, armed, hit, match_cnt
    );

    modport slave (
        input  load_start, pat_valid, pat_data, pat_mask, in_valid, in_data, cnt_clr,
        output pat_ready, armed, hit, match_cnt
    );
endinterface

// File: rtl/seq_pattern_match_word_eq.sv
// Masked equality of one word pair: bits with m=1 must agree, m=0 bits are ignored.
// Purely combinational, no latency, no flow control.
module masked_word_eq #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic             eq
);
    assign eq = ~|((a ^ b) & m);
endmodule

// File: rtl/seq_pattern_match.sv
// Matches a sliding window of stream words against a loadable masked pattern.
// Latency: hit one cycle after the completing in_valid edge; match_cnt updates with it.
// No backpressure: stream words are always accepted while armed, ignored otherwise.
module seq_pattern_match
    import spm_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 3,
    parameter int CNT_W   = 8,
    parameter int OVERLAP = 1
) (
    input logic               clk,
    input logic               rst_n,
    seq_pattern_match_if.slave bus
);
    localparam int               IDX_W    = clog2(DEPTH + 1);
    localparam logic [IDX_W-1:0] FULL     = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   fill_q, fill_d, fill_nxt;
    logic               enter_load, pat_we, shift_en, match;
    logic               hit_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   pat_q  [DEPTH];
    logic [WIDTH-1:0]   mask_q [DEPTH];
    logic [WIDTH-1:0]   win_q  [DEPTH];
    logic [WIDTH-1:0]   win_nxt[DEPTH];
    logic [DEPTH-1:0]   word_eq;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        enter_load = 1'b0;
        pat_we     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.load_start) begin
                    state_d    = ST_LOAD;
                    enter_load = 1'b1;
                end
            end
            ST_LOAD: begin
                // A restart beats a coincident pattern word, which is dropped.
                if (bus.load_start) begin
                    enter_load = 1'b1;
                end else if (bus.pat_valid) begin
                    pat_we = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_ARMED;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_ARMED: begin
                if (bus.load_start) begin
                    state_d    = ST_LOAD;
                    enter_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (enter_load) begin
            idx_d = '0;
        end
    end

    assign shift_en = (state_q == ST_ARMED) && bus.in_valid && !bus.load_start;

    // Window slot 0 is the oldest word and lines up with pattern word 0.
    for (genvar i = 0; i < DEPTH - 1; i++) begin : g_shift
        assign win_nxt[i] = win_q[i + 1];
    end
    assign win_nxt[DEPTH-1] = bus.in_data;

    for (genvar i = 0; i < DEPTH; i++) begin : g_eq
        masked_word_eq #(.WIDTH(WIDTH)) u_eq (
            .a  (win_nxt[i]),
            .b  (pat_q[i]),
            .m  (mask_q[i]),
            .eq (word_eq[i])
        );
    end

    assign fill_nxt = (fill_q == FULL) ? FULL : fill_q + 1'b1;
    assign match    = shift_en && (fill_nxt == FULL) && (&word_eq);

    always_comb begin
        fill_d = fill_q;
        if (enter_load) begin
            fill_d = '0;
        end else if (shift_en) begin
            fill_d = (match && (OVERLAP == 0)) ? '0 : fill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            fill_q  <= '0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            fill_q  <= fill_d;
            hit_q   <= match;
            if (bus.cnt_clr) begin
                cnt_q <= '0;
            end else if (match && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (shift_en) begin
                for (int i = 0; i < DEPTH; i++) begin
                    win_q[i] <= win_nxt[i];
                end
            end
        end
    end

    // Pattern contents are only meaningful once fully loaded, so they carry no reset.
    always_ff @(posedge clk) begin
        if (pat_we) begin
            pat_q[idx_q]  <= bus.pat_data;
            mask_q[idx_q] <= bus.pat_mask;
        end
    end

    assign bus.pat_ready = (state_q == ST_LOAD);
    assign bus.armed     = (state_q == ST_ARMED);
    assign bus.hit       = hit_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_pattern_match.sv
// Three matcher variants (overlap, non-overlap, 2-bit counter) share one stimulus stream;
// a queue-based reference model predicts every cycle's outputs for a decoupled monitor.
module tb_seq_pattern_match;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ls = 1'b0, pv = 1'b0, iv = 1'b0, cc = 1'b0;
    logic [3:0] pd = '0, pm = '0, id = '0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_pattern_match_if #(.WIDTH(4), .CNT_W(8)) if0 ();
    seq_pattern_match_if #(.WIDTH(4), .CNT_W(8)) if1 ();
    seq_pattern_match_if #(.WIDTH(4), .CNT_W(2)) if2 ();

    assign if0.load_start = ls; assign if1.load_start = ls; assign if2.load_start = ls;
    assign if0.pat_valid  = pv; assign if1.pat_valid  = pv; assign if2.pat_valid  = pv;
    assign if0.pat_data   = pd; assign if1.pat_data   = pd; assign if2.pat_data   = pd;
    assign if0.pat_mask   = pm; assign if1.pat_mask   = pm; assign if2.pat_mask   = pm;
    assign if0.in_valid   = iv; assign if1.in_valid   = iv; assign if2.in_valid   = iv;
    assign if0.in_data    = id; assign if1.in_data    = id; assign if2.in_data    = id;
    assign if0.cnt_clr    = cc; assign if1.cnt_clr    = cc; assign if2.cnt_clr    = cc;

    seq_pattern_match #(.WIDTH(4), .DEPTH(3), .CNT_W(8), .OVERLAP(1)) u_ov (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    seq_pattern_match #(.WIDTH(4), .DEPTH(3), .CNT_W(8), .OVERLAP(0)) u_no (
        .clk(clk), .rst_n(rst_n), .bus(if1.slave));
    seq_pattern_match #(.WIDTH(4), .DEPTH(3), .CNT_W(2), .OVERLAP(1)) u_c2 (
        .clk(clk), .rst_n(rst_n), .bus(if2.slave));

    typedef struct packed {
        logic       pr;
        logic       ar;
        logic       hit;
        logic [7:0] cnt;
    } obs_t;

    obs_t exp_q[$];

    // Reference model: pattern as arrays, window as a queue of the most recent words.
    int ov[3]   = '{1, 0, 1};
    int cmax[3] = '{255, 255, 3};
    bit m_load[3], m_arm[3], m_hit[3];
    int m_idx[3], m_cnt[3];
    int m_pat[3][3], m_mask[3][3];
    int m_win[3][$];

    task automatic model_reset(input int k);
        m_load[k] = 0; m_arm[k] = 0; m_hit[k] = 0;
        m_idx[k] = 0; m_cnt[k] = 0;
        m_win[k].delete();
    endtask

    task automatic model_step(input int k);
        bit hn;
        bit ok;
        hn = 0;
        if (!rst_n) begin
            model_reset(k);
            return;
        end
        if (ls) begin
            m_load[k] = 1; m_arm[k] = 0; m_idx[k] = 0;
            m_win[k].delete();
        end else if (m_load[k] && pv) begin
            m_pat[k][m_idx[k]]  = int'(pd);
            m_mask[k][m_idx[k]] = int'(pm);
            m_idx[k]++;
            if (m_idx[k] == 3) begin
                m_load[k] = 0; m_arm[k] = 1;
            end
        end else if (m_arm[k] && iv) begin
            m_win[k].push_back(int'(id));
            if (m_win[k].size() > 3) void'(m_win[k].pop_front());
            if (m_win[k].size() == 3) begin
                ok = 1;
                for (int i = 0; i < 3; i++)
                    if (((m_win[k][i] ^ m_pat[k][i]) & m_mask[k][i]) != 0) ok = 0;
                if (ok) begin
                    hn = 1;
                    if (ov[k] == 0) m_win[k].delete();
                end
            end
        end
        m_hit[k] = hn;
        if (cc) m_cnt[k] = 0;
        else if (hn && m_cnt[k] < cmax[k]) m_cnt[k]++;
    endtask

    function automatic obs_t model_obs(input int k);
        obs_t e;
        e.pr = m_load[k]; e.ar = m_arm[k]; e.hit = m_hit[k]; e.cnt = 8'(m_cnt[k]);
        return e;
    endfunction

    function automatic obs_t dut_obs(input int k);
        obs_t a;
        case (k)
            0: a = '{if0.pat_ready, if0.armed, if0.hit, if0.match_cnt};
            1: a = '{if1.pat_ready, if1.armed, if1.hit, if1.match_cnt};
            default: a = '{if2.pat_ready, if2.armed, if2.hit, {6'b0, if2.match_cnt}};
        endcase
        return a;
    endfunction

    task automatic cyc(input bit r, input bit l, input bit p, input logic [3:0] d,
                       input logic [3:0] m, input bit i, input logic [3:0] x, input bit c);
        @(negedge clk);
        rst_n = r; ls = l; pv = p; pd = d; pm = m; iv = i; id = x; cc = c;
        for (int k = 0; k < 3; k++) begin
            model_step(k);
            exp_q.push_back(model_obs(k));
        end
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc(1, 0, 0, 4'h0, 4'h0, 0, 4'h0, 0);
    endtask

    task automatic strm(input logic [3:0] x, input bit c);
        cyc(1, 0, 0, 4'h0, 4'h0, 1, x, c);
    endtask

    task automatic load3(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [3:0] m0, input logic [3:0] m1, input logic [3:0] m2);
        cyc(1, 1, 0, 4'h0, 4'h0, 0, 4'h0, 0);
        cyc(1, 0, 1, d0, m0, 0, 4'h0, 0);
        cyc(1, 0, 1, d1, m1, 0, 4'h0, 0);
        cyc(1, 0, 1, d2, m2, 0, 4'h0, 0);
    endtask

    task automatic async_rst();
        obs_t a;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            a = dut_obs(k);
            checks++;
            if (a !== '0) begin
                failures++;
                $display("FAIL async_rst inst%0d got pr=%0b ar=%0b hit=%0b cnt=%0d required all 0",
                         k, a.pr, a.ar, a.hit, a.cnt);
            end
            model_reset(k);
        end
    endtask

    // Monitor: every posedge the outputs of all three instances are compared.
    initial begin
        obs_t e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() >= 3) begin
                for (int k = 0; k < 3; k++) begin
                    e = exp_q.pop_front();
                    a = dut_obs(k);
                    checks++;
                    if (a !== e) begin
                        failures++;
                        $display("FAIL mon inst%0d t=%0t got pr=%0b ar=%0b hit=%0b cnt=%0d required pr=%0b ar=%0b hit=%0b cnt=%0d",
                                 k, $time, a.pr, a.ar, a.hit, a.cnt, e.pr, e.ar, e.hit, e.cnt);
                    end
                end
            end
        end
    end

    initial begin
        for (int k = 0; k < 3; k++) model_reset(k);
        cyc(0, 0, 0, 4'h0, 4'h0, 1, 4'h3, 0);
        cyc(0, 1, 0, 4'h0, 4'h0, 0, 4'h0, 0);
        idle(2);

        // Exact pattern with full masks.
        load3(4'hA, 4'h5, 4'hC, 4'hF, 4'hF, 4'hF);
        strm(4'h3, 0); strm(4'hA, 0); strm(4'h5, 0); strm(4'hC, 0);
        idle(2);

        // Repeated word: overlap vs restart behaviour.
        load3(4'hA, 4'hA, 4'hA, 4'hF, 4'hF, 4'hF);
        for (int j = 0; j < 6; j++) strm(4'hA, 0);
        idle(2);

        // Partial masks: middle word ignored, last word low two bits only.
        load3(4'hA, 4'h0, 4'h1, 4'hF, 4'h0, 4'h3);
        strm(4'hA, 0); strm(4'h7, 0); strm(4'hD, 0);
        idle(1);
        strm(4'hA, 0); strm(4'h7, 0); strm(4'hE, 0);
        idle(2);

        // All-zero masks: every word hits once the window is full; saturation and clear.
        load3(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        for (int j = 0; j < 7; j++) strm(4'h5, 0);
        strm(4'h5, 1);
        strm(4'h5, 0);
        idle(2);

        // Restarted load, dropped coincident word, in_valid ignored in LOAD, stale window.
        load3(4'h3, 4'h3, 4'h3, 4'hF, 4'hF, 4'hF);
        strm(4'h3, 0); strm(4'h3, 0); strm(4'h3, 0);
        cyc(1, 1, 0, 4'h0, 4'h0, 1, 4'h3, 0);
        cyc(1, 0, 1, 4'h3, 4'hF, 1, 4'h3, 0);
        cyc(1, 1, 1, 4'h9, 4'hF, 1, 4'h3, 0);
        cyc(1, 0, 1, 4'h3, 4'hF, 1, 4'h3, 0);
        cyc(1, 0, 1, 4'h3, 4'hF, 1, 4'h3, 0);
        cyc(1, 0, 1, 4'h3, 4'hF, 1, 4'h3, 0);
        strm(4'h3, 0);
        idle(1);
        strm(4'h3, 0); strm(4'h3, 0);
        idle(2);

        // Randomized traffic over a small alphabet so matches occur often.
        for (int j = 0; j < 1500; j++) begin
            cyc(1, ($urandom_range(0, 99) < 2), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 3)),
                ($urandom_range(0, 49) == 0));
        end
        idle(2);

        // Asynchronous reset while armed mid-stream, then stream words must be ignored.
        load3(4'h1, 4'h2, 4'h3, 4'hF, 4'hF, 4'hF);
        strm(4'h1, 0); strm(4'h2, 0);
        async_rst();
        cyc(0, 0, 0, 4'h0, 4'h0, 1, 4'h3, 0);
        for (int j = 0; j < 4; j++) strm(4'h3, 0);
        idle(2);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got %0d pending entries required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
